// File: rtl/alu_stage_pipe.sv
// ALU->writeback stage register: valid/ready handshake, flush, hold, forwarding tap, stall counter.
// Define ALU_STAGE_SKID_EN for the 2-entry skid buffer with a registered in_ready.
module alu_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              stg_clk,
    input  logic              reset,
    input  logic              stg_ena,
    input  logic              stg_x,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_c,
    input  logic              in_save_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_c,
    output logic              out_save_to_reg,
    input  logic [RD_W-1:0]   fwd_rs,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] c;
        logic              save;
    } entry_t;

`ifdef ALU_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
`else
    typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           in_ent;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             accept, pop;

`ifdef ALU_STAGE_SKID_EN
    entry_t           skid_q, skid_d;
    logic             in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
`else
    assign in_ready = stg_ena & (~out_valid | out_ready);
`endif

    // Write-enable to x0 is dropped at capture so the head never requests it.
    always_comb begin
        in_ent.rd   = in_rd;
        in_ent.c    = in_c;
        in_ent.save = in_save_to_reg & (in_rd != '0);
    end

    assign out_valid       = (state_q != EMPTY);
    assign out_rd          = main_q.rd;
    assign out_c           = main_q.c;
    assign out_save_to_reg = main_q.save;
    assign fwd_data        = main_q.c;
    assign fwd_hit         = out_valid & main_q.save & (fwd_rs != '0) & (fwd_rs == main_q.rd);
    assign stall_cnt       = stall_cnt_q;

    assign accept = in_valid & in_ready & stg_ena;
    assign pop    = out_valid & out_ready & stg_ena;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef ALU_STAGE_SKID_EN
        skid_d     = skid_q;
        in_ready_d = in_ready_q;
`endif
        if (stg_x) begin
            state_d = EMPTY;
            main_d  = '0;
`ifdef ALU_STAGE_SKID_EN
            skid_d     = '0;
            in_ready_d = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_ent;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_ent;
`ifdef ALU_STAGE_SKID_EN
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_ent;
`endif
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
`ifdef ALU_STAGE_SKID_EN
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
`ifdef ALU_STAGE_SKID_EN
            // Registered ready: low only while both entries are occupied.
            in_ready_d = (state_d != FULL);
`endif
        end
    end

    always_ff @(posedge stg_clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
`ifdef ALU_STAGE_SKID_EN
            skid_q     <= '0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef ALU_STAGE_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
`endif
        end
    end

    always_ff @(posedge stg_clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_stage_pipe.sv
// Self-checking bench for alu_stage_pipe: directed vector table, corner sequences and a
// randomized run against a queue-based model; a CNT_W=2 copy checks counter saturation.
module tb_alu_stage_pipe;

`ifdef ALU_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stg_ena, stg_x, in_valid, in_save, out_ready;
    logic [4:0]  in_rd, fwd_rs;
    logic [31:0] in_c;

    logic        in_ready, out_valid, out_save, fwd_hit;
    logic [4:0]  out_rd;
    logic [31:0] out_c, fwd_data;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_out_save, s_fwd_hit;
    logic [4:0]  s_out_rd;
    logic [31:0] s_out_c, s_fwd_data;
    logic [1:0]  s_stall_cnt;

    alu_stage_pipe #(.DATA_W(32), .RD_W(5), .CNT_W(16)) dut (
        .stg_clk(clk), .reset(reset), .stg_ena(stg_ena), .stg_x(stg_x),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_c(in_c),
        .in_save_to_reg(in_save), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_c(out_c), .out_save_to_reg(out_save),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
    );

    alu_stage_pipe #(.DATA_W(32), .RD_W(5), .CNT_W(2)) dut_sat (
        .stg_clk(clk), .reset(reset), .stg_ena(stg_ena), .stg_x(stg_x),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_rd(in_rd), .in_c(in_c),
        .in_save_to_reg(in_save), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_rd(s_out_rd), .out_c(s_out_c), .out_save_to_reg(s_out_save),
        .fwd_rs(fwd_rs), .fwd_hit(s_fwd_hit), .fwd_data(s_fwd_data), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] c;
        logic        s;
    } ent_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] c;
        logic        s;
        logic [4:0]  rs;
        logic [4:0]  e_rd;
        logic [31:0] e_c;
        logic        e_s;
        logic        e_hit;
    } vec_t;

    ent_t        q[$];
    int unsigned m_cnt, m_cnt2;
    bit          m_zero;
    bit          check_en;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        if (CAP == 2) return q.size() < 2;
        return stg_ena && (q.size() == 0 || out_ready);
    endfunction

    task automatic check_model();
        ent_t h;
        bit   hit;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, m_in_ready());
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("sat_stall_cnt", s_stall_cnt, m_cnt2);
        chk("sat_out_valid", s_out_valid, q.size() != 0);
        chk("sat_in_ready", s_in_ready, m_in_ready());
        if (q.size() != 0) begin
            h   = q[0];
            hit = h.s && (fwd_rs != 0) && (fwd_rs == h.rd);
            chk("out_rd", out_rd, h.rd);
            chk("out_c", out_c, h.c);
            chk("out_save", out_save, h.s);
            chk("fwd_data", fwd_data, h.c);
            chk("fwd_hit", fwd_hit, hit);
            chk("sat_head", {s_out_rd, s_out_c, s_out_save, s_fwd_hit, s_fwd_data},
                {h.rd, h.c, h.s, hit, h.c});
        end else begin
            chk("fwd_hit_empty", fwd_hit, 1'b0);
            if (m_zero) chk("out_cleared", {out_rd, out_c, out_save}, 38'd0);
        end
    endtask

    task automatic model_edge();
        bit rdy, acc, pop;
        rdy = m_in_ready();
        if (!reset) begin
            q.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
            m_zero = 1;
            return;
        end
        if (q.size() != 0 && !out_ready) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (stg_x) begin
            q.delete();
            m_zero = 1;
        end else if (stg_ena) begin
            acc = in_valid && rdy;
            pop = (q.size() != 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back('{in_rd, in_c, in_save && (in_rd != 0)});
                m_zero = 0;
            end
        end
    endtask

    task automatic cycle();
        #1;
        if (check_en) check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  5'd3,  32'hDEADBEEF, 1'b1, 1'b1};
        vt[1] = '{5'd0,  32'h12345678, 1'b1, 5'd0,  5'd0,  32'h12345678, 1'b0, 1'b0};
        vt[2] = '{5'd7,  32'hCAFEF00D, 1'b1, 5'd7,  5'd7,  32'hCAFEF00D, 1'b1, 1'b1};
        vt[3] = '{5'd7,  32'h00000001, 1'b1, 5'd0,  5'd7,  32'h00000001, 1'b1, 1'b0};
        vt[4] = '{5'd31, 32'hFFFFFFFF, 1'b0, 5'd31, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0};
        vt[5] = '{5'd31, 32'h00000000, 1'b1, 5'd30, 5'd31, 32'h00000000, 1'b1, 1'b0};

        reset = 0; stg_ena = 1; stg_x = 0; in_valid = 0; in_rd = 0; in_c = 0;
        in_save = 0; out_ready = 0; fwd_rs = 0;
        m_cnt = 0; m_cnt2 = 0; m_zero = 1; check_en = 0;

        // Reset held for two edges, then released.
        cycle();
        check_en = 1;
        cycle();
        reset = 1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", {out_rd, out_c, out_save}, 38'd0);
        chk("rst_stall_cnt", stall_cnt, 16'd0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Single-beat latency and forwarding vectors, each from an empty stage.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_rd = vt[i].rd; in_c = vt[i].c; in_save = vt[i].s;
            out_ready = 1; fwd_rs = vt[i].rs;
            cycle();
            in_valid = 0;
            #1;
            chk("vec_valid", out_valid, 1'b1);
            chk("vec_rd", out_rd, vt[i].e_rd);
            chk("vec_c", out_c, vt[i].e_c);
            chk("vec_save", out_save, vt[i].e_s);
            chk("vec_fwd_hit", fwd_hit, vt[i].e_hit);
            chk("vec_fwd_data", fwd_data, vt[i].e_c);
            cycle();
        end

        // Back-pressure: A then B with out_ready low, then release.
        out_ready = 0; in_valid = 1; in_save = 1;
        in_rd = 5'd1; in_c = 32'hAAAA0001; cycle();
        in_rd = 5'd2; in_c = 32'hBBBB0002; cycle();
        in_valid = 0; cycle(); cycle();
        #1;
        chk("bp_stall_cnt", stall_cnt, 16'd3);
        chk("bp_sat_cnt", s_stall_cnt, 2'd3);
        chk("bp_head_rd", out_rd, 5'd1);
`ifdef ALU_STAGE_SKID_EN
        chk("bp_full_in_ready", in_ready, 1'b0);
`endif
        out_ready = 1;
        cycle();
        #1;
`ifdef ALU_STAGE_SKID_EN
        chk("bp_b_valid", out_valid, 1'b1);
        chk("bp_b_rd", out_rd, 5'd2);
        chk("bp_ready_back", in_ready, 1'b1);
`else
        chk("bp_drained", out_valid, 1'b0);
`endif
        cycle();

        // Flush while occupied, with a beat offered in the same cycle.
        out_ready = 0; in_valid = 1; in_save = 1;
        in_rd = 5'd4; in_c = 32'h44; cycle();
        in_rd = 5'd5; in_c = 32'h55; cycle();
        stg_x = 1; in_rd = 5'd6; in_c = 32'h66; cycle();
        stg_x = 0; in_valid = 0;
        #1;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_out_data", {out_rd, out_c, out_save}, 38'd0);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fl_no_ghost", out_valid, 1'b0);
        end

        // Stall saturation from a fresh reset, then hold with stg_ena low.
        reset = 0; cycle(); reset = 1;
        out_ready = 0; in_valid = 1; in_rd = 5'd7; in_c = 32'h77777777; in_save = 1;
        cycle();
        stg_ena = 0; in_rd = 5'd9; in_c = 32'h99;
        for (int i = 0; i < 5; i++) cycle();
        #1;
        chk("sat_main_cnt", stall_cnt, 16'd5);
        chk("sat_cnt_max", s_stall_cnt, 2'd3);
        out_ready = 1;
        for (int i = 0; i < 5; i++) cycle();
        #1;
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_rd", out_rd, 5'd7);
        chk("hold_c", out_c, 32'h77777777);
        chk("hold_cnt", stall_cnt, 16'd5);
        chk("hold_in_ready", in_ready, (CAP == 2) ? 1'b1 : 1'b0);
        stg_ena = 1;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) != 0);
            stg_x     = ($urandom_range(0, 99) < 3);
            stg_ena   = ($urandom_range(0, 99) < 85);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_rd     = ($urandom_range(0, 99) < 15) ? 5'd0 : 5'($urandom_range(0, 31));
            in_c      = $urandom;
            in_save   = ($urandom_range(0, 99) < 75);
            if (q.size() != 0 && $urandom_range(0, 1) == 1) fwd_rs = q[0].rd;
            else fwd_rs = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
